// File: rtl/cpu_packet_port_pkg.sv
// Shared definitions for the CPU packet port: read-size encodings, FSM states
// and the packet-length width derivation.
package cpu_packet_port_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_READY   = 2'd1,
        ST_VERDICT = 2'd2
    } state_t;

    // One extra bit so a full buffer's length is representable.
    function automatic int plen_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/packet_bank_ram.sv
// One bank of packet storage: 32-bit simple dual-port RAM with a registered,
// enable-gated read port that holds its output between reads.
module packet_bank_ram #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Storage itself is never cleared; only the output register resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_packet_port.sv
// Packet buffer shared between the snooper (fill) and the BPF CPU (reads, verdict).
// Optional read bounds checking and rd_oob output under PACKET_BOUNDS_CHECK_EN.
module cpu_packet_port
    import cpu_packet_port_pkg::*;
#(
    parameter int PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int PLEN_WIDTH             = plen_width(PACKET_BYTE_ADDR_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [PACKET_BYTE_ADDR_WIDTH-3:0] wr_addr,
    input  logic [31:0]                       wr_data,
    input  logic                              wr_done,
    input  logic [PLEN_WIDTH-1:0]             wr_len,
    output logic                              wr_ready,
    input  logic                              packet_mem_rd_en,
    input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] packet_addr,
    input  logic [1:0]                        transfer_sz,
    output logic [31:0]                       packet_data,
`ifdef PACKET_BOUNDS_CHECK_EN
    output logic                              rd_oob,
`endif
    output logic                              mem_ready,
    output logic [PLEN_WIDTH-1:0]             packet_len,
    input  logic                              cpu_acc,
    input  logic                              cpu_rej,
    output logic                              verdict_valid,
    output logic                              verdict_acc,
    output logic [PLEN_WIDTH-1:0]             verdict_len,
    input  logic                              verdict_ready
);

    localparam int WW = PACKET_BYTE_ADDR_WIDTH - 2;
    localparam int BW = WW - 1;

    state_t                state_q;
    logic                  wr_ready_q;
    logic                  mem_ready_q;
    logic [PLEN_WIDTH-1:0] packet_len_q;
    logic                  verdict_valid_q;
    logic                  verdict_acc_q;
    logic [PLEN_WIDTH-1:0] verdict_len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_FILL;
            wr_ready_q      <= 1'b1;
            mem_ready_q     <= 1'b0;
            packet_len_q    <= '0;
            verdict_valid_q <= 1'b0;
            verdict_acc_q   <= 1'b0;
            verdict_len_q   <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (wr_done) begin
                        state_q      <= ST_READY;
                        packet_len_q <= wr_len;
                        wr_ready_q   <= 1'b0;
                        mem_ready_q  <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (cpu_acc || cpu_rej) begin
                        state_q         <= ST_VERDICT;
                        mem_ready_q     <= 1'b0;
                        verdict_valid_q <= 1'b1;
                        verdict_acc_q   <= cpu_acc & ~cpu_rej;
                        verdict_len_q   <= packet_len_q;
                    end
                end
                ST_VERDICT: begin
                    if (verdict_ready) begin
                        state_q         <= ST_FILL;
                        verdict_valid_q <= 1'b0;
                        packet_len_q    <= '0;
                        wr_ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign wr_ready      = wr_ready_q;
    assign mem_ready     = mem_ready_q;
    assign packet_len    = packet_len_q;
    assign verdict_valid = verdict_valid_q;
    assign verdict_acc   = verdict_acc_q;
    assign verdict_len   = verdict_len_q;

    logic          wr_fire;
    logic          rd_fire;
    logic [WW-1:0] word_idx;
    logic [BW-1:0] pair_idx;
    logic [BW-1:0] even_raddr;
    logic [31:0]   even_rdata;
    logic [31:0]   odd_rdata;

    assign wr_fire  = wr_en && (state_q == ST_FILL);
    assign rd_fire  = packet_mem_rd_en && (state_q == ST_READY);
    assign word_idx = packet_addr[PACKET_BYTE_ADDR_WIDTH-1:2];
    assign pair_idx = word_idx[WW-1:1];
    // For an odd start word the following word sits in the next even slot (wrapping).
    assign even_raddr = word_idx[0] ? pair_idx + 1'b1 : pair_idx;

    packet_bank_ram #(.ADDR_WIDTH(BW)) u_even_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire & ~wr_addr[0]),
        .waddr (wr_addr[WW-1:1]),
        .wdata (wr_data),
        .re    (rd_fire),
        .raddr (even_raddr),
        .rdata (even_rdata)
    );

    packet_bank_ram #(.ADDR_WIDTH(BW)) u_odd_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire & wr_addr[0]),
        .waddr (wr_addr[WW-1:1]),
        .wdata (wr_data),
        .re    (rd_fire),
        .raddr (pair_idx),
        .rdata (odd_rdata)
    );

    logic       odd_first_q;
    logic [1:0] lane_q;
    logic [1:0] size_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            odd_first_q <= 1'b0;
            lane_q      <= 2'd0;
            size_q      <= SZ_WORD;
        end else if (rd_fire) begin
            odd_first_q <= word_idx[0];
            lane_q      <= packet_addr[1:0];
            size_q      <= transfer_sz;
        end
    end

    // Last byte of the second word can never be reached, so the window is 7 bytes.
    logic [55:0] window;
    logic [31:0] aligned;
    logic [31:0] sized;

    assign window = odd_first_q ? {odd_rdata, even_rdata[31:8]}
                                : {even_rdata, odd_rdata[31:8]};

    always_comb begin
        aligned = window[55:24];
        case (lane_q)
            2'd1:    aligned = window[47:16];
            2'd2:    aligned = window[39:8];
            2'd3:    aligned = window[31:0];
            default: aligned = window[55:24];
        endcase
    end

    always_comb begin
        sized = aligned;
        case (size_q)
            SZ_HALF: sized = {16'h0000, aligned[31:16]};
            SZ_BYTE: sized = {24'h000000, aligned[31:24]};
            default: sized = aligned;
        endcase
    end

`ifdef PACKET_BOUNDS_CHECK_EN
    localparam int EW = PLEN_WIDTH + 1;

    logic [2:0]    rd_bytes;
    logic [EW-1:0] rd_end;
    logic          oob;
    logic          zero_q;
    logic          rd_oob_q;

    always_comb begin
        rd_bytes = 3'd4;
        case (transfer_sz)
            SZ_HALF: rd_bytes = 3'd2;
            SZ_BYTE: rd_bytes = 3'd1;
            default: rd_bytes = 3'd4;
        endcase
    end

    assign rd_end = EW'(packet_addr) + EW'(rd_bytes);
    assign oob    = rd_end > EW'(packet_len_q);

    // zero_q follows the held data; rd_oob_q is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q   <= 1'b0;
            rd_oob_q <= 1'b0;
        end else begin
            rd_oob_q <= rd_fire & oob;
            if (rd_fire) begin
                zero_q <= oob;
            end
        end
    end

    assign packet_data = zero_q ? 32'h0 : sized;
    assign rd_oob      = rd_oob_q;
`else
    assign packet_data = sized;
`endif

endmodule

// File: tb/tb_cpu_packet_port.sv
// Self-checking bench for cpu_packet_port; byte-array reference model.
// Build with PACKET_BOUNDS_CHECK_EN defined to cover the bounds-check variant.
module tb_cpu_packet_port;

    localparam int AW     = 6;
    localparam int PW     = AW + 1;
    localparam int NWORDS = 16;
    localparam int NBYTES = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-3:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_done;
    logic [PW-1:0] wr_len;
    logic          wr_ready;
    logic          packet_mem_rd_en;
    logic [AW-1:0] packet_addr;
    logic [1:0]    transfer_sz;
    logic [31:0]   packet_data;
`ifdef PACKET_BOUNDS_CHECK_EN
    logic          rd_oob;
`endif
    logic          mem_ready;
    logic [PW-1:0] packet_len;
    logic          cpu_acc;
    logic          cpu_rej;
    logic          verdict_valid;
    logic          verdict_acc;
    logic [PW-1:0] verdict_len;
    logic          verdict_ready;

    int checks = 0;
    int passes = 0;
    logic [7:0] mem_m [NBYTES];

    cpu_packet_port #(.PACKET_BYTE_ADDR_WIDTH(AW), .PLEN_WIDTH(PW)) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_done          (wr_done),
        .wr_len           (wr_len),
        .wr_ready         (wr_ready),
        .packet_mem_rd_en (packet_mem_rd_en),
        .packet_addr      (packet_addr),
        .transfer_sz      (transfer_sz),
        .packet_data      (packet_data),
`ifdef PACKET_BOUNDS_CHECK_EN
        .rd_oob           (rd_oob),
`endif
        .mem_ready        (mem_ready),
        .packet_len       (packet_len),
        .cpu_acc          (cpu_acc),
        .cpu_rej          (cpu_rej),
        .verdict_valid    (verdict_valid),
        .verdict_acc      (verdict_acc),
        .verdict_len      (verdict_len),
        .verdict_ready    (verdict_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0; wr_len = '0;
        packet_mem_rd_en = 0; packet_addr = '0; transfer_sz = 2'b00;
        cpu_acc = 0; cpu_rej = 0; verdict_ready = 0;
    endtask

    task automatic write_word(input int w, input logic [31:0] d, input logic done,
                              input int len, input logic upd);
        wr_en = 1; wr_addr = w[AW-3:0]; wr_data = d; wr_done = done; wr_len = len[PW-1:0];
        if (upd) for (int b = 0; b < 4; b++) mem_m[w*4+b] = d[31-8*b -: 8];
        tick();
        wr_en = 0; wr_done = 0;
    endtask

    task automatic start_read(input int addr, input logic [1:0] sz);
        packet_mem_rd_en = 1; packet_addr = addr[AW-1:0]; transfer_sz = sz;
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_raw(input int addr, input logic [1:0] sz);
        logic [31:0] v = 0;
        for (int i = 0; i < size_bytes(sz); i++) v = (v << 8) | 32'(mem_m[(addr + i) % NBYTES]);
        return v;
    endfunction

    function automatic logic model_oob(input int addr, input logic [1:0] sz, input int len);
`ifdef PACKET_BOUNDS_CHECK_EN
        return (addr + size_bytes(sz)) > len;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b exp 1", wr_ready); else passes++;
        checks++; if (mem_ready !== 1'b0) $display("FAIL reset_mem_ready: got %b exp 0", mem_ready); else passes++;
        checks++; if (packet_len !== '0) $display("FAIL reset_packet_len: got %0d exp 0", packet_len); else passes++;
        checks++; if (packet_data !== 32'h0) $display("FAIL reset_packet_data: got %h exp 0", packet_data); else passes++;
        checks++; if ({verdict_valid, verdict_acc, verdict_len} !== '0)
            $display("FAIL reset_verdict: got v=%b a=%b l=%0d exp all 0", verdict_valid, verdict_acc, verdict_len); else passes++;
    endtask

    task automatic test_fill();
        cpu_acc = 1;
        write_word(0, 32'h11223344, 1'b0, 0, 1'b1);
        cpu_acc = 0;
        checks++; if ({wr_ready, mem_ready, verdict_valid} !== 3'b100)
            $display("FAIL fill_in_progress: got wr_ready=%b mem_ready=%b vv=%b exp 1 0 0", wr_ready, mem_ready, verdict_valid); else passes++;
        write_word(1, 32'h55667788, 1'b1, 8, 1'b1);
        checks++; if ({wr_ready, mem_ready} !== 2'b01)
            $display("FAIL fill_done_flags: got wr_ready=%b mem_ready=%b exp 0 1", wr_ready, mem_ready); else passes++;
        checks++; if (packet_len !== PW'(8)) $display("FAIL fill_packet_len: got %0d exp 8", packet_len); else passes++;
    endtask

    task automatic test_reads();
        start_read(3, 2'b00); tick(); packet_mem_rd_en = 0;
        checks++; if (packet_data !== 32'h44556677) $display("FAIL rd_word_a3: got %h exp 44556677", packet_data); else passes++;
        start_read(3, 2'b01); tick(); packet_mem_rd_en = 0;
        checks++; if (packet_data !== 32'h00004455) $display("FAIL rd_half_a3: got %h exp 00004455", packet_data); else passes++;
        start_read(6, 2'b10); tick(); packet_mem_rd_en = 0;
        checks++; if (packet_data !== 32'h00000077) $display("FAIL rd_byte_a6: got %h exp 00000077", packet_data); else passes++;
        tick();
        checks++; if (packet_data !== 32'h00000077) $display("FAIL rd_hold: got %h exp 00000077", packet_data); else passes++;
    endtask

    task automatic test_back_to_back();
        start_read(0, 2'b00); tick();
        checks++; if (packet_data !== 32'h11223344) $display("FAIL b2b_word_a0: got %h exp 11223344", packet_data); else passes++;
        start_read(1, 2'b10); tick();
        checks++; if (packet_data !== 32'h00000022) $display("FAIL b2b_byte_a1: got %h exp 00000022", packet_data); else passes++;
        start_read(2, 2'b01); tick();
        packet_mem_rd_en = 0;
        checks++; if (packet_data !== 32'h00003344) $display("FAIL b2b_half_a2: got %h exp 00003344", packet_data); else passes++;
    endtask

    task automatic test_verdict();
        cpu_acc = 1; cpu_rej = 1; tick(); cpu_acc = 0; cpu_rej = 0;
        checks++; if ({verdict_valid, verdict_acc, mem_ready, wr_ready} !== 4'b1000)
            $display("FAIL verdict_both: got vv=%b va=%b mr=%b wr=%b exp 1 0 0 0", verdict_valid, verdict_acc, mem_ready, wr_ready); else passes++;
        checks++; if (verdict_len !== PW'(8)) $display("FAIL verdict_len: got %0d exp 8", verdict_len); else passes++;
        for (int i = 0; i < 3; i++) begin
            start_read(0, 2'b00); tick();
            checks++; if ({verdict_valid, verdict_acc, verdict_len} !== {2'b10, PW'(8)})
                $display("FAIL verdict_hold%0d: got vv=%b va=%b len=%0d exp 1 0 8", i, verdict_valid, verdict_acc, verdict_len); else passes++;
            checks++; if (packet_data !== 32'h00003344) $display("FAIL rd_in_verdict%0d: got %h exp 00003344", i, packet_data); else passes++;
        end
        packet_mem_rd_en = 0;
        verdict_ready = 1; tick(); verdict_ready = 0;
        checks++; if ({verdict_valid, wr_ready, mem_ready} !== 3'b010)
            $display("FAIL verdict_taken: got vv=%b wr=%b mr=%b exp 0 1 0", verdict_valid, wr_ready, mem_ready); else passes++;
        checks++; if (packet_len !== '0) $display("FAIL verdict_len_clr: got %0d exp 0", packet_len); else passes++;
    endtask

    task automatic test_ready_write_and_reset();
        write_word(0, 32'h11223344, 1'b0, 0, 1'b1);
        write_word(1, 32'h55667788, 1'b1, 8, 1'b1);
        write_word(0, 32'hDEADBEEF, 1'b1, 20, 1'b0);
        checks++; if (packet_len !== PW'(8)) $display("FAIL ready_wr_done_ignored: got %0d exp 8", packet_len); else passes++;
        start_read(0, 2'b00); tick(); packet_mem_rd_en = 0;
        checks++; if (packet_data !== 32'h11223344) $display("FAIL ready_wr_ignored: got %h exp 11223344", packet_data); else passes++;
        rst = 1; tick(); rst = 0;
        checks++; if ({mem_ready, wr_ready} !== 2'b01)
            $display("FAIL reset_in_ready: got mr=%b wr=%b exp 0 1", mem_ready, wr_ready); else passes++;
    endtask

`ifdef PACKET_BOUNDS_CHECK_EN
    task automatic test_bounds();
        write_word(0, 32'h11223344, 1'b0, 0, 1'b1);
        write_word(1, 32'h55667788, 1'b1, 8, 1'b1);
        start_read(5, 2'b00); tick(); packet_mem_rd_en = 0;
        checks++; if ({packet_data, rd_oob} !== {32'h0, 1'b1})
            $display("FAIL oob_word_a5: got %h oob=%b exp 0 oob=1", packet_data, rd_oob); else passes++;
        tick();
        checks++; if (rd_oob !== 1'b0) $display("FAIL oob_pulse: got %b exp 0", rd_oob); else passes++;
        start_read(4, 2'b00); tick(); packet_mem_rd_en = 0;
        checks++; if ({packet_data, rd_oob} !== {32'h55667788, 1'b0})
            $display("FAIL inb_word_a4: got %h oob=%b exp 55667788 oob=0", packet_data, rd_oob); else passes++;
        rst = 1; tick(); rst = 0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_data;
        logic        exp_oob;
        int          len, addr;
        logic [1:0]  sz;
        logic        rd, acc, rej;
        do_reset();
        exp_data = 32'h0;
        for (int p = 0; p < 6; p++) begin
            len = (p == 0) ? 0 : (p == 1) ? NBYTES : $urandom_range(0, NBYTES);
            for (int w = 0; w < NWORDS; w++) begin
                cpu_rej = 1'($urandom);
                write_word(w, $urandom, w == NWORDS - 1, len, 1'b1);
            end
            cpu_rej = 0;
            checks++; if ({mem_ready, verdict_valid, packet_len} !== {2'b10, PW'(len)})
                $display("FAIL rnd_fill%0d: got mr=%b vv=%b len=%0d exp 1 0 %0d", p, mem_ready, verdict_valid, packet_len, len); else passes++;
            for (int c = 0; c < 40; c++) begin
                rd = ($urandom_range(0, 4) != 0);
                addr = $urandom_range(0, NBYTES - 1);
                sz = 2'($urandom);
                packet_mem_rd_en = rd; packet_addr = addr[AW-1:0]; transfer_sz = sz;
                exp_oob = rd && model_oob(addr, sz, len);
                if (rd) exp_data = exp_oob ? 32'h0 : model_raw(addr, sz);
                tick();
                checks++; if (packet_data !== exp_data)
                    $display("FAIL rnd_rd p%0d c%0d a=%0d sz=%0d: got %h exp %h", p, c, addr, sz, packet_data, exp_data); else passes++;
`ifdef PACKET_BOUNDS_CHECK_EN
                checks++; if (rd_oob !== exp_oob)
                    $display("FAIL rnd_oob p%0d c%0d: got %b exp %b", p, c, rd_oob, exp_oob); else passes++;
`endif
            end
            packet_mem_rd_en = 0;
            acc = 1'($urandom); rej = acc ? 1'($urandom) : 1'b1;
            cpu_acc = acc; cpu_rej = rej; tick(); cpu_acc = 0; cpu_rej = 0;
            repeat ($urandom_range(0, 3)) tick();
            checks++; if ({verdict_valid, verdict_acc, verdict_len} !== {1'b1, acc & ~rej, PW'(len)})
                $display("FAIL rnd_verdict%0d: got vv=%b va=%b len=%0d exp 1 %b %0d", p, verdict_valid, verdict_acc, verdict_len, acc & ~rej, len); else passes++;
            verdict_ready = 1; tick(); verdict_ready = 0;
            checks++; if ({verdict_valid, wr_ready, packet_len} !== {2'b01, PW'(0)})
                $display("FAIL rnd_handoff%0d: got vv=%b wr=%b len=%0d exp 0 1 0", p, verdict_valid, wr_ready, packet_len); else passes++;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_reads();
        test_back_to_back();
        test_verdict();
        test_ready_write_and_reset();
`ifdef PACKET_BOUNDS_CHECK_EN
        test_bounds();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cpu_packet_port.md
Name: cpu_packet_port

Overview:
- Packet-memory responder serving the BPF CPU core's packet read interface: owns one packet buffer, filled by the snooper, read by the CPU.
- Sequences buffer ownership through three phases: snooper fill, CPU execute, verdict handoff.
- Services byte, half-word and word reads at any byte alignment, including reads that span two buffer words, with fixed 1-cycle latency.

Parameters:
- PACKET_BYTE_ADDR_WIDTH, 12, buffer depth in bytes = 2^PACKET_BYTE_ADDR_WIDTH; minimum 4.
- PLEN_WIDTH, PACKET_BYTE_ADDR_WIDTH+1, width of packet length fields.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  snooper writes one 32-bit word this cycle.
- wr_addr  in  PACKET_BYTE_ADDR_WIDTH-2  word address of the write.
- wr_data  in  32  write data; byte 0 is in bits 31:24 (network order).
- wr_done  in  1  end of packet; wr_len is valid.
- wr_len  in  PLEN_WIDTH  packet length in bytes.
- wr_ready  out  1  buffer accepts writes and wr_done.
- packet_mem_rd_en  in  1  CPU read request.
- packet_addr  in  PACKET_BYTE_ADDR_WIDTH  byte address of the read.
- transfer_sz  in  2  read size: 00 word, 01 half-word, 10 byte, 11 reserved (treated as word).
- packet_data  out  32  read data, right-justified, zero-extended.
- mem_ready  out  1  packet loaded; CPU may run.
- packet_len  out  PLEN_WIDTH  latched packet length.
- cpu_acc  in  1  CPU accept pulse.
- cpu_rej  in  1  CPU reject pulse.
- verdict_valid  out  1  verdict available.
- verdict_acc  out  1  1 = accept, 0 = reject; meaningful only when verdict_valid is high.
- verdict_len  out  PLEN_WIDTH  length of the judged packet.
- verdict_ready  in  1  consumer takes the verdict.

Behaviour:
- Reset values:
  - State FILL.
  - wr_ready=1, mem_ready=0, packet_len=0, packet_data=0.
  - verdict_valid=0, verdict_acc=0, verdict_len=0.
  - Buffer contents are not cleared.
- State FILL:
  - wr_en writes wr_data to wr_addr.
  - wr_done latches packet_len=wr_len and moves to READY next cycle.
  - wr_en and wr_done together: the write completes, then the state transitions.
  - wr_len=0 is legal.
  - cpu_acc/cpu_rej are ignored.
- State READY:
  - wr_ready=0 and mem_ready=1; wr_en and wr_done are ignored.
  - cpu_acc or cpu_rej moves to VERDICT: verdict_acc=cpu_acc & ~cpu_rej (both asserted = reject), verdict_len=packet_len, verdict_valid=1.
- State VERDICT:
  - mem_ready=0 and wr_ready=0.
  - verdict_valid is held stable until verdict_ready.
  - On verdict_valid & verdict_ready: verdict_valid=0, packet_len=0, return to FILL.
- Reads:
  - Honoured only in READY.
  - Storage is split into an even-word bank and an odd-word bank. Word w=packet_addr>>2 and word w+1 are read in the same cycle from opposite banks.
  - Word index wraps modulo 2^(PACKET_BYTE_ADDR_WIDTH-2).
  - The byte lane is selected by packet_addr[1:0]; result is big-endian.
  - Example: bytes 0x11 0x22 0x33 0x44 0x55 at addresses 0..4; word read at addr 1 returns 0x22334455.
  - packet_data is registered and valid exactly one cycle after packet_mem_rd_en.
  - packet_data holds its value when there is no new read.
  - Back-to-back reads are supported, one per cycle.
  - A read while not in READY leaves packet_data unchanged.
- Reset mid-operation: any state returns to FILL with the reset values above; a pending verdict is discarded.

Optional Feature:
- Macro: PACKET_BOUNDS_CHECK_EN.
- Defined:
  - A read where packet_addr + size > packet_len (size 4/2/1 bytes) returns packet_data=0.
  - Adds output rd_oob (1 bit, reset 0), which pulses high for one cycle aligned with that data.
  - The comparison uses PLEN_WIDTH+1 bits so it cannot overflow.
- Not defined:
  - No rd_oob port.
  - Out-of-range and wrapped reads return raw buffer contents.

Decomposition:
- Shared package holds:
  - transfer_sz encodings (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10).
  - State encoding (ST_FILL, ST_READY, ST_VERDICT).
  - The PLEN_WIDTH derivation.
- One sub-module, packet_bank_ram: simple dual-port, 32-bit wide, one write port, one registered read port. It is instantiated twice (even and odd banks); all alignment muxing stays in the top.

Test Plan:
- Fill 2 words 0x11223344, 0x55667788 with wr_len=8, then wr_done -> next cycle mem_ready=1, wr_ready=0, packet_len=8.
- READY, word read at addr 3 -> one cycle later packet_data=0x44556677; half read at addr 3 -> 0x00004455; byte read at addr 6 -> 0x00000077.
- Back-to-back reads at addr 0 (word), 1 (byte), 2 (half) -> on consecutive cycles 0x11223344, 0x00000022, 0x00003344.
- cpu_acc and cpu_rej asserted in the same cycle -> verdict_valid=1, verdict_acc=0, verdict_len=8. Hold verdict_ready=0 for 3 cycles -> outputs stable. verdict_ready=1 -> next cycle state FILL, wr_ready=1, packet_len=0.
- wr_en in READY to word 0 with 0xDEADBEEF -> word read at addr 0 still returns 0x11223344. rst asserted in READY -> next cycle mem_ready=0, wr_ready=1.
- With PACKET_BOUNDS_CHECK_EN, packet_len=8: word read at addr 5 -> packet_data=0, rd_oob=1 for one cycle; word read at addr 4 -> 0x55667788, rd_oob=0.
